// File: rtl/mash_pkg.sv
// rtl/mash_pkg.sv - shared constants and state type for the MASH divide-value blocks
//
// Purpose: constants common to the MASH 1-1-1 modulator and its ratio decoder,
//          plus the decoder's FSM state type.
// Ports:   none (package).
package mash_pkg;

  // Divide-value width driven out of the modulator and into the decoder.
  localparam int DIV_W  = 4;
  // Fractional width of the modulator's in_f input and the decoder's avg_f output.
  localparam int FRAC_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/window_accumulator.sv
// rtl/window_accumulator.sv - running sum, sample count and min/max over one window
//
// Purpose: accumulates accepted divide values for one measurement window.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   clr        restart the window (sum/count to 0, min tracker to all-ones, max to 0)
//   acc_en     in_div is an accepted sample this cycle
//   in_div     divide value
//   sum        running sum including this cycle's accepted sample
//   last       this accept completes the window (count == 2^LOG2_WIN-1)
//   min_trk    running minimum including this cycle's accepted sample
//   max_trk    running maximum including this cycle's accepted sample
module window_accumulator #(
  parameter int LOG2_WIN = 16,
  parameter int DIV_W    = mash_pkg::DIV_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      acc_en,
  input  logic [DIV_W-1:0]          in_div,
  output logic [DIV_W+LOG2_WIN-1:0] sum,
  output logic                      last,
  output logic [DIV_W-1:0]          min_trk,
  output logic [DIV_W-1:0]          max_trk
);
  import mash_pkg::*;

  localparam int SUM_W = DIV_W + LOG2_WIN;
  localparam int CNT_W = LOG2_WIN + 1;

  logic [SUM_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] min_q, min_d;
  logic [DIV_W-1:0] max_q, max_d;

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    min_d = min_q;
    max_d = max_q;
    if (clr) begin
      sum_d = '0;
      cnt_d = '0;
      min_d = '1;
      max_d = '0;
    end else if (acc_en) begin
      sum_d = sum_q + SUM_W'(in_div);
      cnt_d = cnt_q + CNT_W'(1);
      if (in_div < min_q) min_d = in_div;
      if (in_div > max_q) max_d = in_div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      cnt_q <= '0;
      min_q <= '0;
      max_q <= '0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  // The next-state values are exported so the top can publish the finished
  // window on the same edge that absorbs its final sample.
  assign sum     = sum_d;
  assign min_trk = min_d;
  assign max_trk = max_d;
  assign last    = acc_en && !clr && (cnt_q == CNT_W'((1 << LOG2_WIN) - 1));

endmodule

// File: rtl/mash_ratio_decoder.sv
// rtl/mash_ratio_decoder.sv - recovers mean divide ratio and min/max from a MASH stream
//
// Purpose: measures the mean of 2^LOG2_WIN accepted divide values and reports
//          it as integer + left-justified fraction, plus the window min/max.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   start             begin / restart a measurement window
//   in_valid, in_div  divide-value sample stream
//   busy              window is being accumulated
//   done              one-cycle pulse, result registers updated
//   avg_i, avg_f      mean divide value, integer and fractional parts
//   min_div, max_div  extremes of the last completed window
module mash_ratio_decoder #(
  parameter int LOG2_WIN = 16,
  parameter int DIV_W    = mash_pkg::DIV_W,
  parameter int FRAC_W   = mash_pkg::FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DIV_W-1:0]  in_div,
  output logic              busy,
  output logic              done,
  output logic [DIV_W-1:0]  avg_i,
  output logic [FRAC_W-1:0] avg_f,
  output logic [DIV_W-1:0]  min_div,
  output logic [DIV_W-1:0]  max_div
);
  import mash_pkg::*;

  state_e                    state_q, state_d;
  logic                      acc_en;
  logic                      last;
  logic [DIV_W+LOG2_WIN-1:0] sum;
  logic [DIV_W-1:0]          min_trk, max_trk;

  logic                      busy_q, done_q;
  logic [DIV_W-1:0]          avg_i_q, min_q, max_q;
  logic [FRAC_W-1:0]         avg_f_q;

  // A start in RUN discards that cycle's sample: the clear wins over the accept.
  assign acc_en = (state_q == RUN) && in_valid && !start;

  window_accumulator #(
    .LOG2_WIN (LOG2_WIN),
    .DIV_W    (DIV_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (start),
    .acc_en  (acc_en),
    .in_div  (in_div),
    .sum     (sum),
    .last    (last),
    .min_trk (min_trk),
    .max_trk (max_trk)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (start) state_d = RUN;
               else if (last) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      avg_i_q <= '0;
      avg_f_q <= '0;
      min_q   <= '0;
      max_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
      if (state_d == DONE) begin
        // Dividing by 2^LOG2_WIN is a bit split; the remainder is left-justified.
        avg_i_q <= sum[LOG2_WIN+DIV_W-1:LOG2_WIN];
        avg_f_q <= FRAC_W'(sum[LOG2_WIN-1:0]) << (FRAC_W - LOG2_WIN);
        min_q   <= min_trk;
        max_q   <= max_trk;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign avg_i   = avg_i_q;
  assign avg_f   = avg_f_q;
  assign min_div = min_q;
  assign max_div = max_q;

endmodule

// File: tb/tb_mash_ratio_decoder.sv
// tb/tb_mash_ratio_decoder.sv - self-checking bench for mash_ratio_decoder
module tb_mash_ratio_decoder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 16-sample window instance
  logic        start4, valid4, busy4, done4;
  logic [3:0]  div4, avg_i4, min4, max4;
  logic [15:0] avg_f4;
  // 65536-sample window instance for the closed-loop run
  logic        start16, valid16, busy16, done16;
  logic [3:0]  div16, avg_i16, min16, max16;
  logic [15:0] avg_f16;

  mash_ratio_decoder #(.LOG2_WIN(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .in_valid(valid4), .in_div(div4),
    .busy(busy4), .done(done4), .avg_i(avg_i4), .avg_f(avg_f4),
    .min_div(min4), .max_div(max4)
  );

  mash_ratio_decoder #(.LOG2_WIN(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .in_valid(valid16), .in_div(div16),
    .busy(busy16), .done(done16), .avg_i(avg_i16), .avg_f(avg_f16),
    .min_div(min16), .max_div(max16)
  );

  int n_checks = 0;
  int n_err    = 0;
  int smp[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive the window in smp[] into u_dut4 and check the published result.
  // gap_mode: 0 no gaps, 1 one idle cycle before each sample, 2 random 0..2.
  task automatic run_win(input string tag, input int gap_mode, input bit do_start,
                         input bit chain, output int cyc);
    int  sum, mn, mx, ng;
    bit  early, drop;
    sum = 0; mn = 15; mx = 0; early = 0; drop = 0; cyc = 0;
    foreach (smp[i]) begin
      sum += smp[i];
      if (smp[i] < mn) mn = smp[i];
      if (smp[i] > mx) mx = smp[i];
    end
    if (do_start) begin
      // The sample offered alongside start must be discarded.
      start4 = 1'b1; valid4 = 1'b1; div4 = 4'hf;
      tick;
      start4 = 1'b0;
      if (!busy4) drop = 1;
    end
    for (int i = 0; i < smp.size(); i++) begin
      ng = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
      repeat (ng) begin
        valid4 = 1'b0; div4 = 4'($urandom_range(0, 15));
        tick; cyc++;
        if (done4) early = 1;
        if (!busy4) drop = 1;
      end
      valid4 = 1'b1; div4 = 4'(smp[i]);
      tick; cyc++;
      if (i != smp.size() - 1) begin
        if (done4) early = 1;
        if (!busy4) drop = 1;
      end
    end
    valid4 = 1'b0;
    check({tag, "_early_done"}, early, 0);
    check({tag, "_busy_during"}, drop, 0);
    check({tag, "_done"}, done4, 1);
    check({tag, "_busy_at_done"}, busy4, 0);
    check({tag, "_avg_i"}, avg_i4, sum / 16);
    check({tag, "_avg_f"}, avg_f4, (sum % 16) * 4096);
    check({tag, "_min"}, min4, mn);
    check({tag, "_max"}, max4, mx);
    if (chain) begin
      start4 = 1'b1; valid4 = 1'b1; div4 = 4'hf;
      tick;
      start4 = 1'b0; valid4 = 1'b0;
      check({tag, "_chain_busy"}, busy4, 1);
      check({tag, "_chain_done_low"}, done4, 0);
    end else begin
      tick;
      check({tag, "_done_pulse_end"}, done4, 0);
    end
    check({tag, "_avg_i_hold"}, avg_i4, sum / 16);
  endtask

  // Start a window and feed n samples of v without completing it.
  task automatic partial(input int n, input int v, output bit saw_done);
    saw_done = 0;
    start4 = 1'b1; valid4 = 1'b0;
    tick;
    start4 = 1'b0;
    if (done4) saw_done = 1;
    repeat (n) begin
      valid4 = 1'b1; div4 = 4'(v);
      tick;
      if (done4) saw_done = 1;
    end
    valid4 = 1'b0;
  endtask

  // Behavioural MASH 1-1-1 modulator: three cascaded 16-bit accumulators,
  // carries recombined through first and second differences.
  int a1, a2, a3, c2d, c3d, c3dd;
  function automatic int mod_step(input int ii, input int ff);
    int c1, c2, c3, y;
    a1 = a1 + ff; c1 = a1 >> 16; a1 = a1 & 16'hffff;
    a2 = a2 + a1; c2 = a2 >> 16; a2 = a2 & 16'hffff;
    a3 = a3 + a2; c3 = a3 >> 16; a3 = a3 & 16'hffff;
    y = ii + c1 + (c2 - c2d) + (c3 - 2 * c3d + c3dd);
    c3dd = c3d; c3d = c3; c2d = c2;
    return y;
  endfunction

  initial begin
    int  cyc, y, ref_sum, ref_mn, ref_mx, df;
    bit  e, ch, nch, early16;

    rst = 1'b1;
    start4 = 0; valid4 = 0; div4 = 0;
    start16 = 0; valid16 = 0; div16 = 0;
    tick; tick;
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_avg_i4", avg_i4, 0);
    check("rst_avg_f4", avg_f4, 0);
    check("rst_min4", min4, 0);
    check("rst_max4", max4, 0);
    check("rst_busy16", busy16, 0);
    check("rst_done16", done16, 0);
    check("rst_avg_i16", avg_i16, 0);
    check("rst_avg_f16", avg_f16, 0);
    rst = 1'b0;
    // in_valid outside RUN must not start anything
    valid4 = 1'b1; div4 = 4'd3;
    tick;
    check("idle_valid_busy", busy4, 0);
    valid4 = 1'b0;

    // constant 7
    smp = {};
    repeat (16) smp.push_back(7);
    run_win("t1", 0, 1, 0, cyc);
    check("t1_latency", cyc, 16);

    // alternating 3,4
    smp = {};
    for (int i = 0; i < 16; i++) smp.push_back((i % 2 == 0) ? 3 : 4);
    run_win("t2", 0, 1, 0, cyc);

    // gapped 5s
    smp = {};
    repeat (16) smp.push_back(5);
    run_win("t3", 1, 1, 0, cyc);
    check("t3_latency", cyc, 32);

    // restart mid-window
    partial(10, 9, e);
    check("t4a_no_done_partial", e, 0);
    smp = {};
    repeat (16) smp.push_back(4);
    run_win("t4a", 0, 1, 0, cyc);

    // reset mid-window
    partial(8, 6, e);
    rst = 1'b1;
    tick;
    if (done4) e = 1;
    rst = 1'b0;
    tick;
    if (done4) e = 1;
    check("t4b_no_done", e, 0);
    check("t4b_busy", busy4, 0);
    check("t4b_avg_i", avg_i4, 0);
    check("t4b_avg_f", avg_f4, 0);
    check("t4b_min", min4, 0);
    check("t4b_max", max4, 0);

    // start on DONE cycle, then continuation window
    smp = {};
    repeat (16) smp.push_back(int'($urandom_range(0, 15)));
    run_win("t6a", 0, 1, 1, cyc);
    smp = {};
    repeat (16) smp.push_back(int'($urandom_range(0, 15)));
    run_win("t6b", 0, 0, 0, cyc);

    // extremes
    smp = {};
    repeat (16) smp.push_back(15);
    run_win("t7_all15", 0, 1, 0, cyc);
    smp = {};
    repeat (16) smp.push_back(0);
    run_win("t7_all0", 2, 1, 0, cyc);

    // randomized windows with random gaps and occasional chained starts
    ch = 0;
    for (int r = 0; r < 8; r++) begin
      smp = {};
      repeat (16) smp.push_back(int'($urandom_range(0, 15)));
      nch = (r < 7) && ($urandom_range(0, 1) == 1);
      run_win($sformatf("rnd%0d", r), 2, !ch, nch, cyc);
      ch = nch;
    end

    // closed loop with the modulator model, both reset together
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    a1 = 0; a2 = 0; a3 = 0; c2d = 0; c3d = 0; c3dd = 0;
    start16 = 1'b1; valid16 = 1'b0;
    tick;
    start16 = 1'b0;
    check("t5_busy_start", busy16, 1);
    ref_sum = 0; ref_mn = 15; ref_mx = 0; early16 = 0;
    for (int i = 0; i < 65536; i++) begin
      y = mod_step(5, 16'h4000);
      ref_sum += y;
      if (y < ref_mn) ref_mn = y;
      if (y > ref_mx) ref_mx = y;
      valid16 = 1'b1; div16 = 4'(y);
      tick;
      if (i != 65535 && done16) early16 = 1;
    end
    valid16 = 1'b0;
    check("t5_early_done", early16, 0);
    check("t5_done", done16, 1);
    check("t5_avg_i", avg_i16, 5);
    check("t5_avg_i_model", avg_i16, ref_sum >> 16);
    check("t5_avg_f_model", avg_f16, ref_sum & 16'hffff);
    df = int'(avg_f16) - 32'h4000;
    check("t5_avg_f_tol", (df <= 4 && df >= -4), 1);
    check("t5_min_model", min16, ref_mn);
    check("t5_max_model", max16, ref_mx);
    check("t5_min_bound", (min16 >= 2), 1);
    check("t5_max_bound", (max16 <= 9), 1);
    tick;
    check("t5_done_pulse_end", done16, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
